// File: rtl/icache_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
// Address layout is pc = {tag, idx, off, 2'b00}.
package icache_pkg;

    localparam int DEF_WAYS       = 2;
    localparam int DEF_SETS       = 8;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_INVAL
    } state_e;

    // Tag field is sized for the widest legal tag; unused upper bits stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
    } tag_entry_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int line_words, input int sets);
        return 30 - $clog2(line_words) - $clog2(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Refill victim choice: lowest-index invalid way, otherwise the set's
// round-robin pointer (flagged so the caller knows to advance it).
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  i_valid,
    input  logic [WAY_W-1:0] i_rr,
    output logic [WAY_W-1:0] o_victim,
    output logic             o_use_rr
);

    always_comb begin
        o_victim = i_rr;
        o_use_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                o_victim = WAY_W'(w);
                o_use_rr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with round-robin replacement,
// fetch kill, and a one-set-per-cycle whole-cache invalidate sweep.
module icache_nway
    import icache_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                if_pc_i,
    input  logic                       if_valid_req_i,
    input  logic                       flush_i,
    input  logic                       inv_i,
    output logic [31:0]                icache_inst_o,
    output logic                       icache_ready_o,
    output logic                       icache_hit_o,
    output logic                       icache_busy_o,
    output logic [31:0]                icache_addr_o,
    output logic                       icache_valid_req_o,
    input  logic                       mem_ready_i,
    input  logic [32*LINE_WORDS-1:0]   mem_data_i
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(LINE_WORDS, SETS);
    localparam int WAY_W  = way_w(WAYS);
    localparam int LINE_W = 32 * LINE_WORDS;

    tag_entry_t         r_tags [SETS][WAYS];
    logic [LINE_W-1:0]  r_data [SETS][WAYS];
    logic [WAY_W-1:0]   r_rr   [SETS];

    state_e             r_state;
    logic               r_ready;
    logic [31:0]        r_inst;
    logic               r_vreq;
    logic [31:0]        r_addr;
    logic               r_kill;
    logic               r_inv_pend;
    logic [IDX_W-1:0]   r_inv_idx;
    logic [TAG_W-1:0]   r_req_tag;
    logic [IDX_W-1:0]   r_req_idx;
    logic [OFF_W-1:0]   r_req_off;
    logic [WAY_W-1:0]   r_victim;
    logic               r_use_rr;

    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_idx;
    logic [OFF_W-1:0]   w_off;
    logic [29:0]        w_tag_ext;
    logic [29:0]        w_req_tag_ext;
    logic [WAYS-1:0]    w_valid_vec;
    logic [WAYS-1:0]    w_hit_vec;
    logic [WAY_W-1:0]   w_hit_way;
    logic               w_hit;
    logic [LINE_W-1:0]  w_hit_line;
    logic [31:0]        w_hit_word;
    logic [31:0]        w_fill_word;
    logic [WAY_W-1:0]   w_victim;
    logic               w_use_rr;
    logic               w_killed;
    logic               w_unused;

    assign w_tag         = if_pc_i[31 -: TAG_W];
    assign w_idx         = if_pc_i[OFF_W+2 +: IDX_W];
    assign w_off         = if_pc_i[2 +: OFF_W];
    assign w_tag_ext     = {{(30-TAG_W){1'b0}}, w_tag};
    assign w_req_tag_ext = {{(30-TAG_W){1'b0}}, r_req_tag};
    assign w_unused      = ^if_pc_i[1:0];

    always_comb begin
        w_valid_vec = '0;
        w_hit_vec   = '0;
        w_hit_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_valid_vec[w] = r_tags[w_idx][w].valid;
            w_hit_vec[w]   = r_tags[w_idx][w].valid && (r_tags[w_idx][w].tag == w_tag_ext);
            if (w_hit_vec[w]) begin
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_hit       = (|w_hit_vec) && (r_state == ST_IDLE);
    assign w_hit_line  = r_data[w_idx][w_hit_way];
    assign w_hit_word  = w_hit_line[{w_off, 5'b0} +: 32];
    assign w_fill_word = mem_data_i[{r_req_off, 5'b0} +: 32];
    assign w_killed    = r_kill || flush_i;

    icache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .i_valid  (w_valid_vec),
        .i_rr     (r_rr[w_idx]),
        .o_victim (w_victim),
        .o_use_rr (w_use_rr)
    );

    // Data array carries no reset so it can map onto RAM; valid bits gate it.
    always_ff @(posedge clk) begin
        if (r_state == ST_REFILL && mem_ready_i) begin
            r_data[r_req_idx][r_victim] <= mem_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b0;
            r_inst     <= '0;
            r_vreq     <= 1'b0;
            r_addr     <= '0;
            r_kill     <= 1'b0;
            r_inv_pend <= 1'b0;
            r_inv_idx  <= '0;
            r_req_tag  <= '0;
            r_req_idx  <= '0;
            r_req_off  <= '0;
            r_victim   <= '0;
            r_use_rr   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_tags[s][w] <= '0;
                end
            end
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (inv_i) begin
                        r_state   <= ST_INVAL;
                        r_inv_idx <= '0;
                    end else if (if_valid_req_i && !flush_i) begin
                        if (w_hit) begin
                            r_ready <= 1'b1;
                            r_inst  <= w_hit_word;
                        end else begin
                            r_state    <= ST_REFILL;
                            r_vreq     <= 1'b1;
                            r_addr     <= {if_pc_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                            r_req_tag  <= w_tag;
                            r_req_idx  <= w_idx;
                            r_req_off  <= w_off;
                            r_victim   <= w_victim;
                            r_use_rr   <= w_use_rr;
                            r_kill     <= 1'b0;
                            r_inv_pend <= 1'b0;
                        end
                    end
                end
                ST_REFILL: begin
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (inv_i) begin
                        r_inv_pend <= 1'b1;
                    end
                    if (mem_ready_i) begin
                        r_vreq <= 1'b0;
                        r_tags[r_req_idx][r_victim] <= '{valid: 1'b1, tag: w_req_tag_ext};
                        if (r_use_rr && WAYS > 1) begin
                            r_rr[r_req_idx] <= r_rr[r_req_idx] + WAY_W'(1);
                        end
                        if (!w_killed) begin
                            r_ready <= 1'b1;
                            r_inst  <= w_fill_word;
                        end
                        r_inv_idx <= '0;
                        r_state   <= (r_inv_pend || inv_i) ? ST_INVAL : ST_IDLE;
                    end
                end
                ST_INVAL: begin
                    for (int w = 0; w < WAYS; w++) begin
                        r_tags[r_inv_idx][w].valid <= 1'b0;
                    end
                    r_rr[r_inv_idx] <= '0;
                    r_inv_idx       <= r_inv_idx + IDX_W'(1);
                    if (r_inv_idx == IDX_W'(SETS - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign icache_inst_o      = r_inst;
    assign icache_ready_o     = r_ready;
    assign icache_hit_o       = w_hit;
    assign icache_busy_o      = (r_state != ST_IDLE);
    assign icache_addr_o      = r_addr;
    assign icache_valid_req_o = r_vreq;

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: directed scenarios plus random traffic, checked
// against a set/way/round-robin model and a fixed memory image.
module tb_icache_nway;

    localparam int WAYS       = 2;
    localparam int SETS       = 8;
    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = 2;
    localparam int IDX_W      = 3;
    localparam int LINE_BYTES = 4 * LINE_WORDS;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [31:0]               if_pc_i;
    logic                      if_valid_req_i;
    logic                      flush_i;
    logic                      inv_i;
    logic [31:0]               icache_inst_o;
    logic                      icache_ready_o;
    logic                      icache_hit_o;
    logic                      icache_busy_o;
    logic [31:0]               icache_addr_o;
    logic                      icache_valid_req_o;
    logic                      mem_ready_i;
    logic [32*LINE_WORDS-1:0]  mem_data_i;

    icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_pc_i            (if_pc_i),
        .if_valid_req_i     (if_valid_req_i),
        .flush_i            (flush_i),
        .inv_i              (inv_i),
        .icache_inst_o      (icache_inst_o),
        .icache_ready_o     (icache_ready_o),
        .icache_hit_o       (icache_hit_o),
        .icache_busy_o      (icache_busy_o),
        .icache_addr_o      (icache_addr_o),
        .icache_valid_req_o (icache_valid_req_o),
        .mem_ready_i        (mem_ready_i),
        .mem_data_i         (mem_data_i)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_inst = '0;
    logic [31:0] cur_line  = '0;

    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int          m_rr    [SETS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h1;
        if (a == 32'h104) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [32*LINE_WORDS-1:0] line_data(input logic [31:0] base);
        logic [32*LINE_WORDS-1:0] d;
        for (int w = 0; w < LINE_WORDS; w++) d[w*32 +: 32] = mem_word(base + 32'(4*w));
        return d;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / LINE_BYTES) % SETS);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (LINE_BYTES * SETS);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[idx_of(pc)][w] && m_tag[idx_of(pc)][w] == tag_of(pc)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_fill(input logic [31:0] pc);
        int s = idx_of(pc);
        int v = -1;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = tag_of(pc);
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    // Response checker: every ready pulse must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (icache_ready_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ready: got inst %h want no response at %0t", icache_inst_o, $time);
                end else begin
                    chk("inst", icache_inst_o, exp_q.pop_front());
                end
                last_inst = icache_inst_o;
            end else begin
                chk("inst_hold", icache_inst_o, last_inst);
            end
            if (icache_valid_req_o) chk("addr_o", icache_addr_o, cur_line);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic count_inval(input bit poke_inv);
        int cnt = 0;
        while (icache_busy_o && cnt < 50) begin
            cnt++;
            inv_i = (poke_inv && cnt == 3);
            @(negedge clk);
            #1;
        end
        inv_i = 1'b0;
        chk("inval_busy_cycles", cnt, SETS);
        m_clear();
    endtask

    task automatic do_req(input logic [31:0] pc, input int lat, input int flush_cyc,
                          input int inv_cyc, input int exp_hit);
        bit hit;
        bit killed = 1'b0;
        bit inv_seen = 1'b0;
        int hi_cnt = 0;
        @(negedge clk);
        chk("busy_before_req", icache_busy_o, 0);
        if_pc_i = pc;
        if_valid_req_i = 1'b1;
        #1;
        hit = m_hit(pc);
        if (exp_hit >= 0) chk("model_pin_hit", hit, exp_hit);
        chk("hit_o", icache_hit_o, hit);
        if (hit) begin
            exp_q.push_back(mem_word(pc));
            @(negedge clk);
            if_valid_req_i = 1'b0;
            #1;
            chk("hit_resp_taken", exp_q.size(), 0);
        end else begin
            cur_line = pc & ~32'(LINE_BYTES - 1);
            @(negedge clk);
            if_valid_req_i = 1'b0;
            for (int c = 1; c <= lat; c++) begin
                if (c > 1) @(negedge clk);
                flush_i = 1'b0;
                inv_i   = 1'b0;
                if (icache_valid_req_o) hi_cnt++;
                chk("busy_refill", icache_busy_o, 1);
                if (c == flush_cyc) begin flush_i = 1'b1; killed = 1'b1; end
                if (c == inv_cyc)   begin inv_i = 1'b1; inv_seen = 1'b1; end
                if (c == lat) begin
                    mem_ready_i = 1'b1;
                    mem_data_i  = line_data(cur_line);
                    if (!killed) exp_q.push_back(mem_word(pc));
                end
            end
            chk("vreq_held_cycles", hi_cnt, lat);
            m_fill(pc);
            @(negedge clk);
            mem_ready_i = 1'b0;
            flush_i     = 1'b0;
            inv_i       = 1'b0;
            #1;
            chk("vreq_drop", icache_valid_req_o, 0);
            chk("fill_resp_taken", exp_q.size(), 0);
            if (inv_seen) count_inval(1'b0);
        end
    endtask

    task automatic do_inv(input bit with_req, input logic [31:0] pc);
        @(negedge clk);
        chk("busy_before_inv", icache_busy_o, 0);
        inv_i = 1'b1;
        if (with_req) begin
            if_pc_i = pc;
            if_valid_req_i = 1'b1;
        end
        @(negedge clk);
        inv_i = 1'b0;
        if_valid_req_i = 1'b0;
        #1;
        count_inval(1'b1);
    endtask

    task automatic do_flush_req(input logic [31:0] pc);
        @(negedge clk);
        if_pc_i = pc;
        if_valid_req_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        if_valid_req_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("flush_req_busy", icache_busy_o, 0);
        chk("flush_req_vreq", icache_valid_req_o, 0);
    endtask

    task automatic hit_burst(input logic [31:0] base, input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if_pc_i = base + 32'(4*i);
            if_valid_req_i = 1'b1;
            #1;
            chk("burst_model_hit", m_hit(if_pc_i), 1);
            chk("burst_hit_o", icache_hit_o, 1);
            exp_q.push_back(mem_word(if_pc_i));
            @(negedge clk);
        end
        if_valid_req_i = 1'b0;
        #1;
        chk("burst_resp_taken", exp_q.size(), 0);
    endtask

    task automatic reset_mid_refill();
        @(negedge clk);
        chk("busy_before_rst_req", icache_busy_o, 0);
        cur_line = 32'h100;
        if_pc_i = 32'h100;
        if_valid_req_i = 1'b1;
        @(negedge clk);
        if_valid_req_i = 1'b0;
        chk("rst_test_vreq", icache_valid_req_o, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_vreq_now", icache_valid_req_o, 0);
        chk("rst_busy_now", icache_busy_o, 0);
        m_clear();
        last_inst = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ready_i = 1'b1;
        mem_data_i  = line_data(32'h100);
        @(negedge clk);
        mem_ready_i = 1'b0;
        #1;
        chk("late_mem_busy", icache_busy_o, 0);
        do_req(32'h100, 2, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        if_pc_i = '0;
        if_valid_req_i = 1'b0;
        flush_i = 1'b0;
        inv_i = 1'b0;
        mem_ready_i = 1'b0;
        mem_data_i = '0;
        m_clear();
        repeat (3) @(negedge clk);
        chk("rst_ready", icache_ready_o, 0);
        chk("rst_vreq", icache_valid_req_o, 0);
        chk("rst_busy", icache_busy_o, 0);
        chk("rst_inst", icache_inst_o, 0);
        chk("rst_addr", icache_addr_o, 0);
        chk("rst_hit", icache_hit_o, 0);
        rst = 1'b0;

        // cold miss then neighbour hit
        do_req(32'h100, 3, 0, 0, 0);
        chk("cold_inst_lit", last_inst, 32'h1);
        do_req(32'h104, 1, 0, 0, 1);
        chk("hit_inst_lit", last_inst, 32'hDEADBEEF);
        hit_burst(32'h100, 4);

        // replacement in set 0
        do_inv(1'b0, 32'h0);
        do_req(32'h000, 2, 0, 0, 0);
        do_req(32'h080, 1, 0, 0, 0);
        do_req(32'h100, 2, 0, 0, 0);
        do_req(32'h080, 1, 0, 0, 1);
        do_req(32'h000, 1, 0, 0, 0);
        do_req(32'h100, 1, 0, 0, 1);
        do_req(32'h080, 1, 0, 0, 0);

        // flush during refill
        do_req(32'h200, 4, 2, 0, 0);
        do_req(32'h200, 1, 0, 0, 1);
        do_req(32'h208, 1, 0, 0, 1);

        // invalidate
        do_req(32'h040, 2, 0, 0, 0);
        do_req(32'h040, 1, 0, 0, 1);
        do_inv(1'b0, 32'h0);
        do_req(32'h040, 1, 0, 0, 0);

        // invalidate during refill
        do_req(32'h300, 3, 0, 2, 0);
        do_req(32'h040, 1, 0, 0, 0);
        do_req(32'h300, 1, 0, 0, 0);

        // inv and request together, then flush with request
        do_inv(1'b1, 32'h300);
        do_req(32'h300, 1, 0, 0, 0);
        do_flush_req(32'h500);
        do_req(32'h500, 1, 0, 0, 0);

        reset_mid_refill();

        for (int i = 0; i < 400; i++) begin
            int          r   = $urandom_range(0, 99);
            int          lat = $urandom_range(1, 4);
            logic [31:0] pc;
            pc = (32'($urandom_range(0, 3)) << (OFF_W + IDX_W + 2)) |
                 (32'($urandom_range(0, SETS - 1)) << (OFF_W + 2)) |
                 (32'($urandom_range(0, LINE_WORDS - 1)) << 2);
            if (r < 5) begin
                do_inv($urandom_range(0, 1) == 1, pc);
            end else if (r < 11) begin
                do_flush_req(pc);
            end else begin
                do_req(pc, lat,
                       ($urandom_range(0, 99) < 15) ? $urandom_range(1, lat) : 0,
                       ($urandom_range(0, 99) < 5)  ? $urandom_range(1, lat) : 0,
                       -1);
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
